// File: rtl/axistream_forwarder_pkg.sv
// Shared definitions for the packet-mem forwarder and its neighbours.
// - state_t        : FSM state encoding. Packet-mem-side blocks decode it too,
//                    so the numeric values are fixed.
// - BUF_DEPTH      : entries in the output skid buffer. It covers the one-cycle
//                    read latency of packet mem.
// - bytes_per_word : stream bytes per word for a given data width.
package axistream_forwarder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 2;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axistream_forwarder_if.sv
// AXI Stream bundle between the forwarder (master) and the downstream sink (slave).
// Signals:
// - TDATA  : stream data. Byte 0 is TDATA[7:0].
// - TKEEP  : byte enables.
// - TVALID : stream valid.
// - TREADY : stream ready, driven by the sink.
// - TLAST  : last beat of the packet.
interface axistream_forwarder_if
    import axistream_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) ();
    localparam int KEEP_WIDTH = bytes_per_word(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] TDATA;
    logic [KEEP_WIDTH-1:0] TKEEP;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master (output TDATA, output TKEEP, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axistream_forwarder_buf.sv
// Two-entry register FIFO of {data, keep, last} words.
// It catches the word that packet mem returns one cycle after a read, while
// the stream sink applies backpressure.
// Ports:
// - clk, rst_n                        : clock; asynchronous active-low reset.
// - push, push_data/keep/last         : write one entry.
//                                       The caller never pushes while the FIFO is full.
// - pop                               : drop the head entry.
// - head_data/keep/last               : head entry. It holds steady until popped.
// - full, empty, occupancy            : fill status.
module axistream_forwarder_buf
    import axistream_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [KEEP_WIDTH-1:0] push_keep,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [KEEP_WIDTH-1:0] head_keep,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            occupancy
);
    logic [DATA_WIDTH-1:0] data_reg [BUF_DEPTH];
    logic [KEEP_WIDTH-1:0] keep_reg [BUF_DEPTH];
    logic                  last_reg [BUF_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg[gi] <= '0;
                    keep_reg[gi] <= '0;
                    last_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg[gi] <= push_data;
                    keep_reg[gi] <= push_keep;
                    last_reg[gi] <= push_last;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            // A simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = data_reg[rd_ptr_reg];
    assign head_keep = keep_reg[rd_ptr_reg];
    assign head_last = last_reg[rd_ptr_reg];
    assign occupancy = count_reg;
    assign empty     = (count_reg == 2'd0);
    assign full      = (count_reg == 2'(BUF_DEPTH));
endmodule

// File: rtl/axistream_forwarder.sv
// Reads a finished packet back out of packet mem and sends it as an AXI Stream master.
// Ports:
// - clk, rst_n          : clock; asynchronous active-low reset.
// - pkt_ready, pkt_len  : packet available. pkt_len is its length in bytes.
// - rd_addr, rd_en      : packet mem read port.
// - rd_data             : read data. It returns one cycle after rd_en.
// - done                : one-cycle pulse when the whole packet has been sent.
// - axis                : AXI Stream master bundle.
module axistream_forwarder
    import axistream_forwarder_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int PLEN_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_ready,
    input  logic [PLEN_WIDTH-1:0] pkt_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    axistream_forwarder_if.master axis
);
    localparam int BYTES = bytes_per_word(DATA_WIDTH);
    localparam logic [PLEN_WIDTH-1:0] BYTES_P = PLEN_WIDTH'(BYTES);

    state_t                state_reg, state_next;
    logic [PLEN_WIDTH-1:0] reads_left_reg, reads_left_next;
    logic [PLEN_WIDTH-1:0] tail_reg, tail_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
    logic                  inflight_reg;       // read issued last cycle; its data is on rd_data now
    logic                  inflight_last_reg;  // that read fetched the final beat

    logic [PLEN_WIDTH-1:0] len_tail, len_beats;
    logic [BYTES-1:0]      tail_keep, push_keep;
    logic [DATA_WIDTH-1:0] head_data;
    logic [BYTES-1:0]      head_keep;
    logic                  head_last, buf_full, buf_empty, pop, room;
    logic [1:0]            occupancy;

    assign len_tail  = pkt_len % BYTES_P;
    assign len_beats = (pkt_len / BYTES_P) + {{(PLEN_WIDTH-1){1'b0}}, (len_tail != '0)};

    // Keep mask for the final beat: set the low `tail` bytes, or all bytes when tail is 0.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_keep
            assign tail_keep[gi] = (tail_reg == '0) || (tail_reg > PLEN_WIDTH'(gi));
        end
    endgenerate
    assign push_keep = inflight_last_reg ? tail_keep : '1;

    assign pop = ~buf_empty & axis.TREADY;
    // Count the word that leaves this cycle as already gone. This lets a new
    // read overlap a pop and keeps one beat per cycle when TREADY stays high.
    // The buffer still never receives a word while it is full.
    assign room = (({1'b0, occupancy} + {2'b00, inflight_reg} - {2'b00, pop}) < 3'd2)
                  && (!buf_full || pop);

    always_comb begin
        state_next      = state_reg;
        reads_left_next = reads_left_reg;
        tail_next       = tail_reg;
        rd_addr_next    = rd_addr_reg;
        rd_en           = 1'b0;
        done            = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                rd_addr_next = '0;
                if (pkt_ready) begin
                    if (pkt_len == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        tail_next       = len_tail;
                        reads_left_next = len_beats;
                        state_next      = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if ((reads_left_reg != '0) && room) begin
                    rd_en           = 1'b1;
                    reads_left_next = reads_left_reg - PLEN_WIDTH'(1);
                    // Hold the address on the final read so it never passes beats-1.
                    if (reads_left_reg > PLEN_WIDTH'(1))
                        rd_addr_next = rd_addr_reg + ADDR_WIDTH'(1);
                    else
                        state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_next   = ST_DONE;
                    rd_addr_next = '0;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                rd_addr_next = '0;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            reads_left_reg    <= '0;
            tail_reg          <= '0;
            rd_addr_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            reads_left_reg    <= reads_left_next;
            tail_reg          <= tail_next;
            rd_addr_reg       <= rd_addr_next;
            inflight_reg      <= rd_en;
            inflight_last_reg <= rd_en && (reads_left_reg == PLEN_WIDTH'(1));
        end
    end

    assign rd_addr = rd_addr_reg;

    axistream_forwarder_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (BYTES)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_data (rd_data),
        .push_keep (push_keep),
        .push_last (inflight_last_reg),
        .pop       (pop),
        .head_data (head_data),
        .head_keep (head_keep),
        .head_last (head_last),
        .full      (buf_full),
        .empty     (buf_empty),
        .occupancy (occupancy)
    );

    assign axis.TVALID = ~buf_empty;
    assign axis.TDATA  = head_data;
    assign axis.TKEEP  = head_keep;
    assign axis.TLAST  = head_last;
endmodule

// File: tb/tb_axistream_forwarder.sv
`timescale 1ns/1ps
module tb_axistream_forwarder;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam int PW = 32;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pkt_ready = 1'b0;
    logic [PW-1:0] pkt_len = '0;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          done;

    axistream_forwarder_if #(.DATA_WIDTH(DW)) axis ();

    axistream_forwarder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PLEN_WIDTH(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_ready (pkt_ready),
        .pkt_len   (pkt_len),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .done      (done),
        .axis      (axis)
    );

    always #5 clk = ~clk;

    // Packet mem model with a one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;
    beat_t sb_q[$];
    beat_t sb_e;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // TREADY driver: either held high, or cycled through 1,0,0,1,0,1.
    int   tready_mode = 0;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    initial begin
        int ph;
        ph = 0;
        axis.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 0) begin
                axis.TREADY = 1'b1;
            end else begin
                axis.TREADY = pat[ph];
                ph = (ph + 1) % 6;
            end
        end
    end

    // Monitor: scoreboard, buffer-occupancy model, address and stability checks.
    int                 occ_m = 0, infl_m = 0, exp_addr = 0, pkt_beats = 0, done_total = 0;
    logic               prev_hs = 0, prev_rd = 0, stall_prev = 0, hs;
    logic [DW+KW:0]     stall_word;
    always @(negedge clk) begin
        if (!rst_n) begin
            occ_m = 0; infl_m = 0; prev_hs = 0; prev_rd = 0; stall_prev = 0; exp_addr = 0;
        end else begin
            occ_m  = occ_m + infl_m - (prev_hs ? 1 : 0);
            infl_m = prev_rd ? 1 : 0;
            hs     = axis.TVALID && axis.TREADY;
            check("tvalid_vs_model", axis.TVALID, occ_m != 0);
            if (stall_prev)
                check("stall_stable", {axis.TVALID, axis.TDATA, axis.TKEEP, axis.TLAST},
                      {1'b1, stall_word});
            if (rd_en) begin
                check("rd_addr", rd_addr, exp_addr);
                exp_addr++;
                check("rd_en_room", (occ_m + infl_m - (hs ? 1 : 0)) < 2, 1);
            end
            if (done) begin
                done_total++;
                exp_addr = 0;
            end
            if (hs) begin
                pkt_beats++;
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got data %0h with empty scoreboard", axis.TDATA);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("tdata", axis.TDATA, sb_e.data);
                    check("tkeep", axis.TKEEP, sb_e.keep);
                    check("tlast", axis.TLAST, sb_e.last);
                end
            end
            stall_prev = axis.TVALID && !axis.TREADY;
            stall_word = {axis.TDATA, axis.TKEEP, axis.TLAST};
            prev_hs    = hs;
            prev_rd    = rd_en;
        end
    end

    task automatic load_packet(input int beats, input logic [KW-1:0] keep);
        for (int i = 0; i < beats; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < beats; i++)
            sb_q.push_back('{data: mem[i], keep: (i == beats - 1) ? keep : '1, last: (i == beats - 1)});
    endtask

    task automatic wait_done(output int lat, output logic got);
        lat = 0; got = 0;
        while (lat < 500 && !got) begin
            @(negedge clk); #1;
            lat++;
            if (done) got = 1;
        end
    endtask

    task automatic run_packet(input int len, input int beats, input logic [KW-1:0] keep,
                              input int mode, input int exp_lat);
        int   lat, d0;
        logic got;
        tready_mode = mode;
        load_packet(beats, keep);
        pkt_beats = 0;
        d0 = done_total;
        @(negedge clk);
        pkt_ready = 1'b1;
        pkt_len   = PW'(len);
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        wait_done(lat, got);
        check("done_seen", got, 1);
        if (exp_lat != 0) check("done_latency", lat, exp_lat);
        check("beat_count", pkt_beats, beats);
        @(negedge clk); #1;
        check("done_one_cycle", done, 0);
        check("rd_addr_idle", rd_addr, 0);
        check("done_pulses", done_total - d0, 1);
        check("sb_drained", sb_q.size(), 0);
        $display("packet len=%0d beats=%0d mode=%0d lat=%0d", len, pkt_beats, mode, lat);
    endtask

    typedef struct {
        int          len;
        int          exp_beats;
        logic [KW-1:0] exp_keep;
        int          mode;
        int          exp_lat;   // 0: not checked (stalling sink)
    } vec_t;
    vec_t vecs[8];

    initial begin
        int   k, d0, lat, gap;
        logic got;
        vecs[0] = '{24, 3, 8'hFF, 0, 6};
        vecs[1] = '{13, 2, 8'h1F, 0, 5};
        vecs[2] = '{8,  1, 8'hFF, 0, 4};
        vecs[3] = '{40, 5, 8'hFF, 1, 0};
        vecs[4] = '{0,  0, 8'h00, 0, 1};
        vecs[5] = '{1,  1, 8'h01, 0, 4};
        vecs[6] = '{63, 8, 8'h7F, 0, 11};
        vecs[7] = '{17, 3, 8'h01, 1, 0};

        // Reset state.
        rst_n = 1'b0;
        #1;
        check("reset_tvalid", axis.TVALID, 0);
        check("reset_tlast", axis.TLAST, 0);
        check("reset_tkeep", axis.TKEEP, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++)
            run_packet(vecs[v].len, vecs[v].exp_beats, vecs[v].exp_keep, vecs[v].mode, vecs[v].exp_lat);

        // Reset in the middle of a 5-beat packet.
        tready_mode = 0;
        load_packet(5, 8'hFF);
        pkt_beats = 0;
        d0 = done_total;
        @(negedge clk);
        pkt_ready = 1'b1;
        pkt_len   = PW'(40);
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        k = 0;
        while (pkt_beats < 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("midpkt_reached", pkt_beats, 2);
        @(posedge clk); #2;
        check("midpkt_tvalid_before", axis.TVALID, 1);
        rst_n = 1'b0;
        #1;
        check("midpkt_tvalid_async", axis.TVALID, 0);
        check("midpkt_done", done, 0);
        check("midpkt_rd_en", rd_en, 0);
        check("midpkt_rd_addr", rd_addr, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midpkt_no_done", done_total - d0, 0);
        $display("reset mid-packet after %0d beats", pkt_beats);
        run_packet(16, 2, 8'hFF, 0, 5);

        // Back-to-back packets with pkt_ready held high.
        tready_mode = 0;
        load_packet(2, 8'hFF);
        sb_q.push_back('{data: mem[0], keep: 8'hFF, last: 1'b1});
        pkt_beats = 0;
        d0 = done_total;
        @(negedge clk);
        pkt_ready = 1'b1;
        pkt_len   = PW'(16);
        @(posedge clk); #1;
        pkt_len   = PW'(8);
        wait_done(lat, got);
        check("b2b_done1", got, 1);
        check("b2b_beats1", pkt_beats, 2);
        gap = 0;
        got = 0;
        while (gap < 20 && !got) begin
            @(negedge clk); #1;
            gap++;
            if (rd_en) got = 1;
        end
        check("b2b_gap", gap, 2);
        pkt_ready = 1'b0;
        wait_done(lat, got);
        check("b2b_done2", got, 1);
        @(negedge clk); #1;
        check("b2b_done_pulses", done_total - d0, 2);
        check("b2b_beats_total", pkt_beats, 3);
        check("b2b_sb_drained", sb_q.size(), 0);
        $display("back-to-back: beats=%0d gap=%0d", pkt_beats, gap);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
